// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hz_ctrl_t;

    // x0 is hardwired zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_sched_fwd.sv
// Per-operand forwarding select; the younger M result beats the W result.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    output fwd_sel_e         sel
);

    always_comb begin
        sel = FWD_RF;
        if (regwrite_m && reg_match(rd_m, rs)) begin
            sel = FWD_M;
        end else if (regwrite_w && reg_match(rd_w, rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Hazard controller: forwarding, load-use stall, branch flush, mul/div sequencing
// with timeout, and a saturating stall-cycle counter.
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic [REG_W-1:0] rs1E,
    input  logic [REG_W-1:0] rs2E,
    input  logic [REG_W-1:0] rdE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             loadE,
    input  logic             pcsrcE,
    input  logic             mdE,
    input  logic             md_done,
    output logic [SEL_W-1:0] forwardAE,
    output logic [SEL_W-1:0] forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned          TMO_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    md_state_e         state;
    md_state_e         state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_nxt;
    logic              err_nxt;
    logic              md_stall;
    logic              load_use;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;
    hz_ctrl_t          ctrl;

    fwd_unit u_fwd_a (
        .rs         (rs1E),
        .rd_m       (rdM),
        .rd_w       (rdW),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .sel        (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs         (rs2E),
        .rd_m       (rdM),
        .rd_w       (rdW),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .sel        (fwd_b)
    );

    assign forwardAE = fwd_a;
    assign forwardBE = fwd_b;

    assign load_use = loadE && (reg_match(rdE, rs1D) || reg_match(rdE, rs2D));

    // Mul/div sequencer: done pulses outside BUSY are ignored by construction
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        err_nxt     = md_err;
        md_start    = 1'b0;
        md_stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mdE && !pcsrcE) begin
                    md_start  = 1'b1;
                    md_stall  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_nxt   = DONE;
                    tmo_cnt_nxt = '0;
                end else begin
                    md_stall = 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        err_nxt     = 1'b1;
                        state_nxt   = DONE;
                        tmo_cnt_nxt = '0;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                tmo_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            md_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            md_err  <= err_nxt;
        end
    end

    // The md freeze holds E, so the load-use bubble into E is withheld until release
    always_comb begin
        ctrl         = '0;
        ctrl.stall_f = load_use || md_stall;
        ctrl.stall_d = load_use || md_stall;
        ctrl.stall_e = md_stall;
        ctrl.flush_m = md_stall;
        ctrl.flush_e = (load_use || pcsrcE) && !md_stall;
        ctrl.flush_d = pcsrcE;
    end

    assign stallF  = ctrl.stall_f;
    assign stallD  = ctrl.stall_d;
    assign stallE  = ctrl.stall_e;
    assign flushD  = ctrl.flush_d;
    assign flushE  = ctrl.flush_e;
    assign flushM  = ctrl.flush_m;
    assign md_busy = (state == BUSY);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (ctrl.stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios plus randomized traffic
// against a behavioural model of the hazard rules.
module tb_hazard_sched;

    localparam int unsigned TMO     = 8;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SCNT_W  = 3;
    localparam longint      CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam int          SCNT_MAX = (1 << SCNT_W) - 1;

    logic             CLK = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             regwriteM, regwriteW, loadE, pcsrcE, mdE, md_done;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE, flushD, flushE, flushM;
    logic             md_start, md_busy, md_err;
    logic [CNT_W-1:0] stall_cnt;

    logic [1:0]        s_fa, s_fb;
    logic              s_stallF, s_stallD, s_stallE, s_flushD, s_flushE, s_flushM;
    logic              s_start, s_busy, s_err;
    logic [SCNT_W-1:0] s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: an operation in flight, its age, a one-cycle cool-down after it ends
    bit     m_inflight, m_cool, m_err;
    int     m_age;
    longint m_cnt;
    int     m_cnt_s;

    logic [1:0] e_fa, e_fb;
    bit e_stall, e_stallE, e_flushD, e_flushE, e_flushM, e_start, e_busy;

    hazard_sched #(.MD_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .pcsrcE(pcsrcE), .mdE(mdE), .md_done(md_done),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .md_start(md_start), .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    hazard_sched #(.MD_TIMEOUT(TMO), .CNT_W(SCNT_W)) dut_small (
        .CLK(CLK), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .pcsrcE(pcsrcE), .mdE(mdE), .md_done(md_done),
        .forwardAE(s_fa), .forwardBE(s_fb), .stallF(s_stallF), .stallD(s_stallD),
        .stallE(s_stallE), .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
        .md_start(s_start), .md_busy(s_busy), .md_err(s_err), .stall_cnt(s_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_eval();
        bit lu, want, hold;
        lu   = loadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
        want = !m_inflight && !m_cool && mdE && !pcsrcE;
        hold = want || (m_inflight && !md_done);
        e_fa     = ref_fwd(rs1E);
        e_fb     = ref_fwd(rs2E);
        e_start  = want;
        e_busy   = m_inflight;
        e_stall  = lu || hold;
        e_stallE = hold;
        e_flushM = hold;
        e_flushD = pcsrcE;
        e_flushE = (lu || pcsrcE) && !hold;
    endfunction

    function automatic void model_reset();
        m_inflight = 0; m_cool = 0; m_err = 0; m_age = 0; m_cnt = 0; m_cnt_s = 0;
    endfunction

    task automatic set_idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteM = 0; regwriteW = 0; loadE = 0; pcsrcE = 0; mdE = 0; md_done = 0;
    endtask

    // Advance one clock, updating the model with the inputs held across the edge
    task automatic tick();
        model_eval();
        @(posedge CLK);
        if (e_stall) begin
            if (m_cnt != CNT_MAX) m_cnt++;
            if (m_cnt_s != SCNT_MAX) m_cnt_s++;
        end
        if (m_cool) begin
            m_cool = 0;
        end else if (m_inflight) begin
            if (md_done) begin
                m_inflight = 0; m_cool = 1;
            end else if (m_age == TMO - 1) begin
                m_err = 1; m_inflight = 0; m_cool = 1;
            end else begin
                m_age++;
            end
        end else if (e_start) begin
            m_inflight = 1; m_age = 0;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", md_busy); end
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b exp 0", md_start); end
        n_checks++; if (md_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", md_err); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", stall_cnt); end
        n_checks++; if ({forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM} !== 10'd0) begin
            n_fail++; $display("FAIL rst_comb: got %b exp 0", {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM});
        end
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        set_idle();
        rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1;
        #1;
        n_checks++; if (forwardAE !== 2'b10) begin n_fail++; $display("FAIL fwdA_m_prio: got %b exp 10", forwardAE); end
        rdM = 0;
        #1;
        n_checks++; if (forwardAE !== 2'b01) begin n_fail++; $display("FAIL fwdA_w: got %b exp 01", forwardAE); end
        rs2E = 0; rdW = 0;
        #1;
        n_checks++; if (forwardBE !== 2'b00) begin n_fail++; $display("FAIL fwdB_x0: got %b exp 00", forwardBE); end
        rs2E = 9; rdM = 9; regwriteM = 0; rdW = 9; regwriteW = 1;
        #1;
        n_checks++; if (forwardBE !== 2'b01) begin n_fail++; $display("FAIL fwdB_m_disabled: got %b exp 01", forwardBE); end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        loadE = 1; rdE = 7; rs2D = 7;
        #1;
        n_checks++; if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin
            n_fail++; $display("FAIL lu_stall: got F/D/flE/E=%b exp 1110", {stallF, stallD, flushE, stallE});
        end
        n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL lu_cnt_before: got %0d exp 0", stall_cnt); end
        tick();
        set_idle();
        #1;
        n_checks++; if ({stallF, flushE} !== 2'b00) begin n_fail++; $display("FAIL lu_one_cycle: got %b exp 00", {stallF, flushE}); end
        n_checks++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL lu_cnt_after: got %0d exp 1", stall_cnt); end
        loadE = 1; rdE = 0; rs1D = 0;
        #1;
        n_checks++; if (stallF !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b exp 0", stallF); end
        tick();
    endtask

    task automatic test_muldiv();
        set_idle();
        mdE = 1; md_done = 1;
        #1;
        n_checks++; if ({md_start, stallE, flushM, flushE, md_busy} !== 5'b11100) begin
            n_fail++; $display("FAIL md_c0: got start/stE/flM/flE/busy=%b exp 11100", {md_start, stallE, flushM, flushE, md_busy});
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            md_done = 0;
            #1;
            n_checks++; if ({md_busy, md_start, stallF, stallE} !== 4'b1011) begin
                n_fail++; $display("FAIL md_busy_c%0d: got busy/start/stF/stE=%b exp 1011", c, {md_busy, md_start, stallF, stallE});
            end
            tick();
        end
        md_done = 1;
        #1;
        n_checks++; if ({md_busy, stallE, stallF} !== 3'b100) begin
            n_fail++; $display("FAIL md_c4: got busy/stE/stF=%b exp 100", {md_busy, stallE, stallF});
        end
        tick();
        #1;
        n_checks++; if ({md_busy, md_start, stallF} !== 3'b000) begin
            n_fail++; $display("FAIL md_done_state: got busy/start/stF=%b exp 000", {md_busy, md_start, stallF});
        end
        tick();
        mdE = 0;
        #1;
        n_checks++; if ({md_busy, md_start} !== 2'b00) begin n_fail++; $display("FAIL md_idle: got %b exp 00", {md_busy, md_start}); end
        n_checks++; if (stall_cnt !== 5) begin n_fail++; $display("FAIL md_cnt: got %0d exp 5", stall_cnt); end
        tick();
        md_done = 0;
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_stray_done: got %b exp 0", md_busy); end
        tick();
    endtask

    task automatic test_timeout();
        set_idle();
        mdE = 1;
        #1;
        n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b exp 1", md_start); end
        tick();
        for (int c = 0; c < int'(TMO); c++) begin
            #1;
            n_checks++; if ({md_busy, stallE, md_err} !== 3'b110) begin
                n_fail++; $display("FAIL tmo_busy_c%0d: got busy/stE/err=%b exp 110", c, {md_busy, stallE, md_err});
            end
            tick();
        end
        mdE = 0;
        #1;
        n_checks++; if ({md_busy, stallE, stallF, md_err} !== 4'b0001) begin
            n_fail++; $display("FAIL tmo_release: got busy/stE/stF/err=%b exp 0001", {md_busy, stallE, stallF, md_err});
        end
        repeat (3) tick();
        #1;
        n_checks++; if (md_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b exp 1", md_err); end
    endtask

    task automatic test_branch();
        set_idle();
        pcsrcE = 1;
        #1;
        n_checks++; if ({flushD, flushE, stallE, stallF} !== 4'b1100) begin
            n_fail++; $display("FAIL br_flush: got flD/flE/stE/stF=%b exp 1100", {flushD, flushE, stallE, stallF});
        end
        tick();
        loadE = 1; rdE = 3; rs1D = 3;
        #1;
        n_checks++; if ({flushD, flushE, stallF, stallD, stallE} !== 5'b11110) begin
            n_fail++; $display("FAIL br_lu: got flD/flE/stF/stD/stE=%b exp 11110", {flushD, flushE, stallF, stallD, stallE});
        end
        tick();
        set_idle();
        pcsrcE = 1; mdE = 1;
        #1;
        n_checks++; if ({md_start, stallE} !== 2'b00) begin n_fail++; $display("FAIL br_md_blocked: got %b exp 00", {md_start, stallE}); end
        tick();
        set_idle();
        #1;
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL br_md_idle: got %b exp 0", md_busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rs1D = 5'($urandom_range(0, 7)); rs2D = 5'($urandom_range(0, 7));
            rs1E = 5'($urandom_range(0, 7)); rs2E = 5'($urandom_range(0, 7));
            rdE  = 5'($urandom_range(0, 7)); rdM  = 5'($urandom_range(0, 7));
            rdW  = 5'($urandom_range(0, 7));
            regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
            loadE   = ($urandom_range(0, 2) == 0);
            pcsrcE  = ($urandom_range(0, 5) == 0);
            mdE     = ($urandom_range(0, 3) == 0);
            md_done = ($urandom_range(0, 4) == 0);
            #1;
            model_eval();
            n_checks++; if (forwardAE !== e_fa) begin n_fail++; $display("FAIL rnd_fwdA @%0d: got %b exp %b", i, forwardAE, e_fa); end
            n_checks++; if (forwardBE !== e_fb) begin n_fail++; $display("FAIL rnd_fwdB @%0d: got %b exp %b", i, forwardBE, e_fb); end
            n_checks++; if ({stallF, stallD} !== {e_stall, e_stall}) begin
                n_fail++; $display("FAIL rnd_stallFD @%0d: got %b exp %b", i, {stallF, stallD}, {e_stall, e_stall});
            end
            n_checks++; if (stallE !== e_stallE) begin n_fail++; $display("FAIL rnd_stallE @%0d: got %b exp %b", i, stallE, e_stallE); end
            n_checks++; if ({flushD, flushE, flushM} !== {e_flushD, e_flushE, e_flushM}) begin
                n_fail++; $display("FAIL rnd_flush @%0d: got %b exp %b", i, {flushD, flushE, flushM}, {e_flushD, e_flushE, e_flushM});
            end
            n_checks++; if (md_start !== e_start) begin n_fail++; $display("FAIL rnd_start @%0d: got %b exp %b", i, md_start, e_start); end
            n_checks++; if (md_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b exp %b", i, md_busy, e_busy); end
            n_checks++; if (md_err !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b exp %b", i, md_err, m_err); end
            n_checks++; if (stall_cnt !== m_cnt[CNT_W-1:0]) begin
                n_fail++; $display("FAIL rnd_cnt @%0d: got %0d exp %0d", i, stall_cnt, m_cnt);
            end
            n_checks++; if (s_cnt !== SCNT_W'(m_cnt_s)) begin
                n_fail++; $display("FAIL rnd_cnt_sat @%0d: got %0d exp %0d", i, s_cnt, m_cnt_s);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        set_idle();
        mdE = 1;
        tick();
        tick();
        #1;
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rmo_busy_before: got %b exp 1", md_busy); end
        rst_n = 1'b0;
        mdE = 0;
        #1;
        n_checks++; if ({md_busy, md_err, stallE} !== 3'b000) begin
            n_fail++; $display("FAIL rmo_async: got busy/err/stE=%b exp 000", {md_busy, md_err, stallE});
        end
        n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL rmo_cnt: got %0d exp 0", stall_cnt); end
        model_reset();
        @(negedge CLK);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if ({md_start, md_busy} !== 2'b00) begin
                n_fail++; $display("FAIL rmo_no_restart_c%0d: got %b exp 00", c, {md_start, md_busy});
            end
            tick();
        end
        mdE = 1;
        #1;
        n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL rmo_new_start: got %b exp 1", md_start); end
        tick();
        mdE = 0; md_done = 1;
        #1;
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rmo_new_busy: got %b exp 1", md_busy); end
        tick();
        set_idle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_timeout();
        test_branch();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
